// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_controller
// Description : Control FSM for a multi-cycle processor. Sequences
//               FETCH/DECODE/EXEC/MEM/WB, drives the datapath strobes,
//               counts retired instructions and latches a fault code on
//               entry to HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_controller #(
    parameter int RETIRED_W = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [4:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    input  logic                 ras_full,
    input  logic                 ras_empty,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 reg_write,
    output logic                 alu_src,
    output logic                 ras_push,
    output logic                 ras_pop,
    output logic [2:0]           state,
    output logic [1:0]           fault,
    output logic [RETIRED_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [4:0] OP_R    = 5'd0;
    localparam logic [4:0] OP_I    = 5'd1;
    localparam logic [4:0] OP_S    = 5'd2;
    localparam logic [4:0] OP_BEQ  = 5'd3;
    localparam logic [4:0] OP_BNE  = 5'd4;
    localparam logic [4:0] OP_JMP  = 5'd5;
    localparam logic [4:0] OP_CALL = 5'd6;
    localparam logic [4:0] OP_RET  = 5'd7;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_RAS = 2'b11;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_ILL  = 2'b01;
    localparam logic [1:0] FLT_OVF  = 2'b10;
    localparam logic [1:0] FLT_UNF  = 2'b11;

    state_t     cur_state;
    state_t     nxt_state;
    logic [1:0] fault_q;
    logic [1:0] nxt_fault;
    logic       retire;

    assign state = cur_state;
    assign fault = fault_q;

    // State, fault code and retire counter; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_FETCH;
            fault_q   <= FLT_NONE;
            retired   <= '0;
        end else begin
            cur_state <= nxt_state;
            fault_q   <= nxt_fault;
            if (retire) begin
                retired <= retired + RETIRED_W'(1);
            end
        end
    end

    // Next-state, fault and strobe decode; strobes are forced low while reset is asserted
    always_comb begin
        nxt_state = cur_state;
        nxt_fault = fault_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_INC;
        reg_write = 1'b0;
        alu_src   = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;

        if (rst) begin
            case (cur_state)
                S_FETCH: begin
                    // Idle until run; a stalled fetch keeps the request up
                    if (run) begin
                        mem_req = 1'b1;
                        if (mem_ready) begin
                            ir_write  = 1'b1;
                            pc_write  = 1'b1;
                            pc_src    = PC_INC;
                            nxt_state = S_DECODE;
                        end
                    end
                end

                S_DECODE: begin
                    case (opcode)
                        OP_R, OP_I, OP_S, OP_BEQ, OP_BNE: begin
                            nxt_state = S_EXEC;
                        end
                        OP_JMP: begin
                            pc_write  = 1'b1;
                            pc_src    = PC_JMP;
                            retire    = 1'b1;
                            nxt_state = S_FETCH;
                        end
                        OP_CALL: begin
                            if (ras_full) begin
                                nxt_state = S_HALT;
                                nxt_fault = FLT_OVF;
                            end else begin
                                ras_push  = 1'b1;
                                pc_write  = 1'b1;
                                pc_src    = PC_JMP;
                                retire    = 1'b1;
                                nxt_state = S_FETCH;
                            end
                        end
                        OP_RET: begin
                            if (ras_empty) begin
                                nxt_state = S_HALT;
                                nxt_fault = FLT_UNF;
                            end else begin
                                ras_pop   = 1'b1;
                                pc_write  = 1'b1;
                                pc_src    = PC_RAS;
                                retire    = 1'b1;
                                nxt_state = S_FETCH;
                            end
                        end
                        default: begin
                            nxt_state = S_HALT;
                            nxt_fault = FLT_ILL;
                        end
                    endcase
                end

                S_EXEC: begin
                    // Immediate operand for I-type and for the store address
                    alu_src = (opcode == OP_I) || (opcode == OP_S);
                    case (opcode)
                        OP_R, OP_I: begin
                            nxt_state = S_WB;
                        end
                        OP_S: begin
                            nxt_state = S_MEM;
                        end
                        OP_BEQ: begin
                            if (zero) begin
                                pc_write = 1'b1;
                                pc_src   = PC_BR;
                            end
                            retire    = 1'b1;
                            nxt_state = S_FETCH;
                        end
                        OP_BNE: begin
                            if (!zero) begin
                                pc_write = 1'b1;
                                pc_src   = PC_BR;
                            end
                            retire    = 1'b1;
                            nxt_state = S_FETCH;
                        end
                        default: begin
                            // Only reachable if the IR changed under us
                            nxt_state = S_HALT;
                            nxt_fault = FLT_ILL;
                        end
                    endcase
                end

                S_MEM: begin
                    // Store: hold the write request until memory accepts it
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    alu_src = 1'b1;
                    if (mem_ready) begin
                        retire    = 1'b1;
                        nxt_state = S_FETCH;
                    end
                end

                S_WB: begin
                    reg_write = 1'b1;
                    alu_src   = (opcode == OP_I);
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                end

                S_HALT: begin
                    nxt_state = S_HALT;
                end

                default: begin
                    // Unused codes 5 and 6
                    nxt_state = S_HALT;
                    nxt_fault = FLT_ILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_controller
// Description : Randomized self-checking bench for multi_cycle_controller.
//               Each instruction is expanded into its expected cycle trace
//               from the instruction-level rules and compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_controller;

    // Narrow counter so the wrap-around is reachable in a short run
    localparam int RW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [4:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          ras_full;
    logic          ras_empty;
    logic          mem_req;
    logic          mem_we;
    logic          ir_write;
    logic          pc_write;
    logic [1:0]    pc_src;
    logic          reg_write;
    logic          alu_src;
    logic          ras_push;
    logic          ras_pop;
    logic [2:0]    state;
    logic [1:0]    fault;
    logic [RW-1:0] retired;

    int            n_checks = 0;
    int            n_pass   = 0;

    // Reference model state: instruction-level view only
    logic [RW-1:0] m_ret;
    logic [1:0]    m_fault;
    bit            halted;

    multi_cycle_controller #(.RETIRED_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .alu_src   (alu_src),
        .ras_push  (ras_push),
        .ras_pop   (ras_pop),
        .state     (state),
        .fault     (fault),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({state, mem_req, mem_we, ir_write, pc_write, pc_src,
                    reg_write, alu_src, ras_push, ras_pop, fault, retired});
    endfunction

    function automatic logic [63:0] pk(input logic [2:0] st, input logic mreq, input logic mwe,
                                       input logic irw, input logic pcw, input logic [1:0] src,
                                       input logic rw, input logic asrc, input logic push,
                                       input logic pop);
        return 64'({st, mreq, mwe, irw, pcw, src, rw, asrc, push, pop, m_fault, m_ret});
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] rop();
        return 5'($urandom);
    endfunction

    // One clock: drive inputs, check at the falling edge, advance past the rising edge
    task automatic step(input string tag, input logic r, input logic rdy, input logic z,
                        input logic full, input logic empty, input logic [4:0] op,
                        input logic [63:0] exp, input bit ret);
        run = r; mem_ready = rdy; zero = z; ras_full = full; ras_empty = empty; opcode = op;
        @(negedge clk);
        check(tag, dut_vec(), exp);
        @(posedge clk);
        #1;
        if (ret) m_ret = m_ret + RW'(1);
    endtask

    // Asserts reset wherever we are in the cycle; strobes must drop at once
    task automatic do_reset();
        run = 1'b1; mem_ready = 1'b1;
        rst = 1'b0;
        #1;
        m_ret = '0; m_fault = 2'b00; halted = 1'b0;
        check("rst_async", dut_vec(), pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check("rst_hold", dut_vec(), pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++)
            step("halt", rb(), rb(), rb(), rb(), rb(), rop(),
                 pk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    endtask

    // Expected trace of one instruction from its class and side conditions
    task automatic do_instr(input logic [4:0] op, input int idle, input int fstall, input int mstall,
                            input logic z, input logic full, input logic empty);
        logic is_i, is_s, taken;
        is_i  = (op == 5'd1);
        is_s  = (op == 5'd2);
        taken = ((op == 5'd3) && z) || ((op == 5'd4) && !z);
        for (int i = 0; i < idle; i++)
            step("fetch_idle", 1'b0, rb(), rb(), rb(), rb(), rop(),
                 pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < fstall; i++)
            step("fetch_stall", 1'b1, 1'b0, rb(), rb(), rb(), rop(),
                 pk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        step("fetch", 1'b1, 1'b1, rb(), rb(), rb(), rop(),
             pk(3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        if (op <= 5'd4) begin
            step("decode", rb(), rb(), rb(), full, empty, op,
                 pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        end else if (op == 5'd5) begin
            step("jmp", rb(), rb(), rb(), full, empty, op,
                 pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
            return;
        end else if (op == 5'd6 && !full) begin
            step("call", rb(), rb(), rb(), full, empty, op,
                 pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
            return;
        end else if (op == 5'd7 && !empty) begin
            step("ret", rb(), rb(), rb(), full, empty, op,
                 pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
            return;
        end else begin
            step("decode_fault", rb(), rb(), rb(), full, empty, op,
                 pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
            m_fault = (op == 5'd6) ? 2'b10 : (op == 5'd7) ? 2'b11 : 2'b01;
            halted  = 1'b1;
            return;
        end
        step("exec", rb(), rb(), z, rb(), rb(), op,
             pk(3'd2, 1'b0, 1'b0, 1'b0, taken, taken ? 2'b01 : 2'b00, 1'b0, is_i | is_s, 1'b0, 1'b0),
             op >= 5'd3);
        if (op >= 5'd3) return;
        if (is_s) begin
            for (int i = 0; i < mstall; i++)
                step("mem_wait", rb(), 1'b0, rb(), rb(), rb(), op,
                     pk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0);
            step("mem_done", rb(), 1'b1, rb(), rb(), rb(), op,
                 pk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
        end else begin
            step("wb", rb(), rb(), rb(), rb(), rb(), op,
                 pk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, is_i, 1'b0, 1'b0), 1'b1);
        end
    endtask

    // Reset dropped mid-cycle during a stalled fetch or a stalled store
    task automatic reset_mid(input bit in_mem);
        if (in_mem) begin
            step("s_fetch", 1'b1, 1'b1, rb(), rb(), rb(), rop(),
                 pk(3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
            step("s_decode", rb(), rb(), rb(), rb(), rb(), 5'd2,
                 pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
            step("s_exec", rb(), rb(), rb(), rb(), rb(), 5'd2,
                 pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0);
            run = 1'b1; mem_ready = 1'b0; opcode = 5'd2;
            @(negedge clk);
            check("mem_stall_pre_rst", dut_vec(),
                  pk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        end else begin
            run = 1'b1; mem_ready = 1'b0; opcode = rop();
            @(negedge clk);
            check("fetch_stall_pre_rst", dut_vec(),
                  pk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        #2;
        do_reset();
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        ras_full = 1'b0; ras_empty = 1'b0; opcode = 5'd0;
        m_ret = '0; m_fault = 2'b00; halted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // R-type, no stalls
        do_instr(5'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("r_retired", 64'(retired), 64'(1));
        // Store with three memory stall cycles
        do_instr(5'd2, 1, 2, 3, 1'b0, 1'b0, 1'b0);
        check("s_retired", 64'(retired), 64'(2));
        // BEQ not taken, BNE taken, both with zero=0
        do_reset();
        do_instr(5'd3, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr(5'd4, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("branch_retired", 64'(retired), 64'(2));
        // Successful JMP/CALL/RET and I-type
        do_instr(5'd5, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr(5'd6, 0, 1, 0, 1'b0, 1'b0, 1'b1);
        do_instr(5'd7, 2, 0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(5'd1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        // CALL overflow: halts, count frozen, fault held
        do_instr(5'd6, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        halt_cycles(5);
        check("ovf_fault", 64'(fault), 64'(2'b10));
        check("ovf_retired", 64'(retired), 64'(6));
        do_reset();
        // RET underflow
        do_instr(5'd7, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        halt_cycles(3);
        check("unf_fault", 64'(fault), 64'(2'b11));
        do_reset();
        // Illegal opcode 01010
        do_instr(5'b01010, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        halt_cycles(3);
        check("ill_state", 64'(state), 64'(3'd7));
        do_reset();
        // Reset mid-instruction
        do_instr(5'd5, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        reset_mid(1'b0);
        do_instr(5'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        reset_mid(1'b1);
        check("mid_rst_retired", 64'(retired), 64'(0));

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : rop();
            do_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                     rb(), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            if (halted) begin
                halt_cycles($urandom_range(1, 3));
                do_reset();
            end else if ($urandom_range(0, 30) == 0) begin
                reset_mid(rb());
            end
        end

        // Counter wrap-around: fill to all-ones with JMPs, then one more
        do_reset();
        for (int n = 0; n < (1 << RW) - 1; n++)
            do_instr(5'd5, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("pre_wrap", 64'(retired), 64'((1 << RW) - 1));
        do_instr(5'd5, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("wrap", 64'(retired), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
